// File: rtl/cp0_except_commit.sv
// rtl/cp0_except_commit.sv - commits exception/ERET/MTC0 updates into CP0 state and owns the Count/Compare timer
//
// Purpose: applies the registered exception request at the commit point to
// Status/Cause/EPC/BadVAddr, merges MTC0 writes through per-register write
// masks, runs the Count/Compare timer, synchronises the hardware interrupt
// lines and issues a one-cycle fetch redirect after every flush.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   except_*                 exception request (flush, code, eret, delayslot,
//                            cur_pc, jump_pc, extra)
//   wb_cp0_*                 MTC0 write request (we, waddr, sel, wdata)
//   ext_int                  asynchronous level interrupt inputs -> IP[7:2]
//   cp0_*                    registered CP0 register snapshot
//   interrupt_flag           Cause.IP & Status.IM
//   timer_int                latched Count==Compare interrupt (Cause.TI)
//   redirect_valid/_pc       one-cycle fetch redirect after a flush
module cp0_except_commit #(
   parameter int EXT_INT_W = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 except_flush,
   input  logic [4:0]           except_code,
   input  logic                 except_eret,
   input  logic                 except_delayslot,
   input  logic [31:0]          except_cur_pc,
   input  logic [31:0]          except_jump_pc,
   input  logic [31:0]          except_extra,
   input  logic                 wb_cp0_we,
   input  logic [4:0]           wb_cp0_waddr,
   input  logic [2:0]           wb_cp0_sel,
   input  logic [31:0]          wb_cp0_wdata,
   input  logic [EXT_INT_W-1:0] ext_int,
   output logic [31:0]          cp0_status,
   output logic [31:0]          cp0_cause,
   output logic [31:0]          cp0_epc,
   output logic [31:0]          cp0_error_epc,
   output logic [31:0]          cp0_badvaddr,
   output logic [31:0]          cp0_count,
   output logic [31:0]          cp0_compare,
   output logic [7:0]           interrupt_flag,
   output logic                 timer_int,
   output logic                 redirect_valid,
   output logic [31:0]          redirect_pc
);

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;
   localparam logic [4:0] REG_ERROREPC = 5'd30;

   // Software-writable bits: Status BEV, IM, ERL, EXL, IE; Cause IP[1:0] only.
   localparam logic [31:0] STATUS_WMASK = 32'h0040_FF07;
   localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
   localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

   localparam logic [4:0] EXC_MOD  = 5'd1;
   localparam logic [4:0] EXC_TLBL = 5'd2;
   localparam logic [4:0] EXC_TLBS = 5'd3;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_CPU  = 5'd11;

   logic [31:0] status_q, cause_q, epc_q, error_epc_q, badvaddr_q, count_q, compare_q;
   logic [31:0] status_n, cause_n, epc_n, error_epc_n, badvaddr_n, count_n, compare_n;
   logic        toggle_q, toggle_n, timer_n;
   logic [EXT_INT_W-1:0] ext_sync1_q, ext_sync2_q;
   logic [5:0]  ext_ip;
   logic        wr;

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [31:0] mask);
      return (new_v & mask) | (old_v & ~mask);
   endfunction

   always_comb begin
      wr = wb_cp0_we && (wb_cp0_sel == 3'd0);

      // MTC0 merge first; commit updates below override the fields they touch.
      status_n    = (wr && wb_cp0_waddr == REG_STATUS) ? merge(status_q, wb_cp0_wdata, STATUS_WMASK) : status_q;
      cause_n     = (wr && wb_cp0_waddr == REG_CAUSE)  ? merge(cause_q, wb_cp0_wdata, CAUSE_WMASK)   : cause_q;
      epc_n       = (wr && wb_cp0_waddr == REG_EPC)      ? wb_cp0_wdata : epc_q;
      error_epc_n = (wr && wb_cp0_waddr == REG_ERROREPC) ? wb_cp0_wdata : error_epc_q;
      compare_n   = (wr && wb_cp0_waddr == REG_COMPARE)  ? wb_cp0_wdata : compare_q;
      badvaddr_n  = badvaddr_q;

      if (except_flush && !except_eret) begin
         // EXL from the merged view decides whether EPC/BD are captured.
         if (!status_n[1]) begin
            epc_n       = except_delayslot ? except_cur_pc - 32'd4 : except_cur_pc;
            cause_n[31] = except_delayslot;
         end
         cause_n[6:2] = except_code;
         status_n[1]  = 1'b1;
         if (except_code == EXC_ADEL || except_code == EXC_ADES || except_code == EXC_TLBL ||
             except_code == EXC_TLBS || except_code == EXC_MOD)
            badvaddr_n = except_extra;
         if (except_code == EXC_CPU)
            cause_n[29:28] = except_extra[1:0];
      end else if (except_flush && except_eret) begin
         if (status_n[2])
            status_n[2] = 1'b0;
         else
            status_n[1] = 1'b0;
      end

      // Count ticks at half the clock rate; a write reloads it and restarts the phase.
      if (wr && wb_cp0_waddr == REG_COUNT) begin
         count_n  = wb_cp0_wdata;
         toggle_n = 1'b0;
      end else begin
         count_n  = toggle_q ? count_q + 32'd1 : count_q;
         toggle_n = ~toggle_q;
      end

      // Match is sticky; only a Compare write clears it, and that write beats a match.
      timer_n = (wr && wb_cp0_waddr == REG_COMPARE) ? 1'b0 : (timer_int | (count_q == compare_q));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         status_q       <= STATUS_RESET;
         cause_q        <= '0;
         epc_q          <= '0;
         error_epc_q    <= '0;
         badvaddr_q     <= '0;
         count_q        <= '0;
         compare_q      <= '0;
         toggle_q       <= 1'b0;
         timer_int      <= 1'b0;
         ext_sync1_q    <= '0;
         ext_sync2_q    <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         status_q       <= status_n;
         cause_q        <= cause_n;
         epc_q          <= epc_n;
         error_epc_q    <= error_epc_n;
         badvaddr_q     <= badvaddr_n;
         count_q        <= count_n;
         compare_q      <= compare_n;
         toggle_q       <= toggle_n;
         timer_int      <= timer_n;
         ext_sync1_q    <= ext_int;
         ext_sync2_q    <= ext_sync1_q;
         redirect_valid <= except_flush;
         if (except_flush)
            redirect_pc <= except_jump_pc;
      end
   end

   // Hardware IP bits are live views of the synchroniser and timer, never stored in cause_q.
   assign ext_ip         = 6'(ext_sync2_q) | {timer_int, 5'b0};
   assign cp0_status     = status_q;
   assign cp0_cause      = cause_q | {1'b0, timer_int, 14'b0, ext_ip, 10'b0};
   assign cp0_epc        = epc_q;
   assign cp0_error_epc  = error_epc_q;
   assign cp0_badvaddr   = badvaddr_q;
   assign cp0_count      = count_q;
   assign cp0_compare    = compare_q;
   assign interrupt_flag = cp0_cause[15:8] & status_q[15:8];

   // BadVAddr is read-only to MTC0.
   logic unused_badvaddr_addr;
   assign unused_badvaddr_addr = (wb_cp0_waddr == REG_BADVADDR);

endmodule

// File: tb/tb_cp0_except_commit.sv
// tb/tb_cp0_except_commit.sv - randomized and directed bench for cp0_except_commit
module tb_cp0_except_commit;

   logic        clk = 1'b0;
   logic        rst;
   logic        except_flush, except_eret, except_delayslot;
   logic [4:0]  except_code;
   logic [31:0] except_cur_pc, except_jump_pc, except_extra;
   logic        wb_cp0_we;
   logic [4:0]  wb_cp0_waddr;
   logic [2:0]  wb_cp0_sel;
   logic [31:0] wb_cp0_wdata;
   logic [5:0]  ext_int;
   logic [31:0] cp0_status, cp0_cause, cp0_epc, cp0_error_epc, cp0_badvaddr, cp0_count, cp0_compare;
   logic [7:0]  interrupt_flag;
   logic        timer_int, redirect_valid;
   logic [31:0] redirect_pc;

   int checks = 0;
   int failures = 0;

   cp0_except_commit #(.EXT_INT_W(6)) dut (
      .clk(clk), .rst(rst),
      .except_flush(except_flush), .except_code(except_code), .except_eret(except_eret),
      .except_delayslot(except_delayslot), .except_cur_pc(except_cur_pc),
      .except_jump_pc(except_jump_pc), .except_extra(except_extra),
      .wb_cp0_we(wb_cp0_we), .wb_cp0_waddr(wb_cp0_waddr), .wb_cp0_sel(wb_cp0_sel),
      .wb_cp0_wdata(wb_cp0_wdata), .ext_int(ext_int),
      .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
      .cp0_error_epc(cp0_error_epc), .cp0_badvaddr(cp0_badvaddr), .cp0_count(cp0_count),
      .cp0_compare(cp0_compare), .interrupt_flag(interrupt_flag), .timer_int(timer_int),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   // Reference model kept as architectural fields rather than packed registers.
   bit        m_bev, m_erl, m_exl, m_ie, m_bd, m_ti, m_rv;
   bit [7:0]  m_im;
   bit [1:0]  m_ce, m_ipsw;
   bit [4:0]  m_exc;
   bit [5:0]  m_ext_seen, m_ext_vis;
   bit [31:0] m_epc, m_eepc, m_bva, m_cmp, m_base, m_rpc;
   int unsigned m_ticks;

   function automatic bit [31:0] exp_count();
      return m_base + 32'(m_ticks / 2);
   endfunction

   function automatic bit [31:0] exp_status();
      return {9'b0, m_bev, 6'b0, m_im, 5'b0, m_erl, m_exl, m_ie};
   endfunction

   function automatic bit [31:0] exp_cause();
      return {m_bd, m_ti, m_ce, 12'b0, m_ext_vis | {m_ti, 5'b0}, m_ipsw, 1'b0, m_exc, 2'b0};
   endfunction

   task automatic model_step();
      bit wr, new_ti;
      if (rst) begin
         m_bev = 1; m_erl = 0; m_exl = 0; m_ie = 0; m_im = 0;
         m_bd = 0; m_ti = 0; m_ce = 0; m_ipsw = 0; m_exc = 0;
         m_epc = 0; m_eepc = 0; m_bva = 0; m_cmp = 0; m_base = 0; m_ticks = 0;
         m_ext_seen = 0; m_ext_vis = 0; m_rv = 0; m_rpc = 0;
         return;
      end
      wr = wb_cp0_we && wb_cp0_sel == 0;
      new_ti = (wr && wb_cp0_waddr == 11) ? 1'b0 : (m_ti || exp_count() == m_cmp);
      m_ext_vis  = m_ext_seen;
      m_ext_seen = ext_int;
      if (wr && wb_cp0_waddr == 9) begin
         m_base = wb_cp0_wdata; m_ticks = 0;
      end else begin
         m_ticks++;
      end
      if (wr) begin
         case (wb_cp0_waddr)
            11: m_cmp = wb_cp0_wdata;
            12: begin
               m_bev = wb_cp0_wdata[22]; m_im = wb_cp0_wdata[15:8];
               m_erl = wb_cp0_wdata[2]; m_exl = wb_cp0_wdata[1]; m_ie = wb_cp0_wdata[0];
            end
            13: m_ipsw = wb_cp0_wdata[9:8];
            14: m_epc = wb_cp0_wdata;
            30: m_eepc = wb_cp0_wdata;
            default: ;
         endcase
      end
      if (except_flush && !except_eret) begin
         if (!m_exl) begin
            m_epc = except_delayslot ? except_cur_pc - 4 : except_cur_pc;
            m_bd  = except_delayslot;
         end
         m_exc = except_code;
         m_exl = 1;
         if (except_code inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd5}) m_bva = except_extra;
         if (except_code == 5'd11) m_ce = except_extra[1:0];
      end else if (except_flush && except_eret) begin
         if (m_erl) m_erl = 0;
         else m_exl = 0;
      end
      m_rv = except_flush;
      if (except_flush) m_rpc = except_jump_pc;
      m_ti = new_ti;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("status", cp0_status, exp_status());
      chk("cause", cp0_cause, exp_cause());
      chk("epc", cp0_epc, m_epc);
      chk("error_epc", cp0_error_epc, m_eepc);
      chk("badvaddr", cp0_badvaddr, m_bva);
      chk("count", cp0_count, exp_count());
      chk("compare", cp0_compare, m_cmp);
      chk("timer_int", 32'(timer_int), 32'(m_ti));
      chk("interrupt_flag", 32'(interrupt_flag), 32'(exp_cause() >> 8 & 32'hFF & 32'(m_im)));
      chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
      if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
   endtask

   task automatic set_idle();
      except_flush = 0; except_eret = 0; except_delayslot = 0; except_code = 0;
      except_cur_pc = 0; except_jump_pc = 0; except_extra = 0;
      wb_cp0_we = 0; wb_cp0_waddr = 0; wb_cp0_sel = 0; wb_cp0_wdata = 0;
   endtask

   // One clock: model consumes the inputs, DUT is compared 1 ns after the edge.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
      set_idle();
   endtask

   task automatic do_wr(input logic [4:0] a, input logic [31:0] d);
      wb_cp0_we = 1; wb_cp0_waddr = a; wb_cp0_sel = 0; wb_cp0_wdata = d;
   endtask

   task automatic do_exc(input logic [4:0] code, input logic ds, input logic [31:0] pc,
                         input logic [31:0] jpc, input logic [31:0] extra, input logic eret);
      except_flush = 1; except_code = code; except_delayslot = ds; except_cur_pc = pc;
      except_jump_pc = jpc; except_extra = extra; except_eret = eret;
   endtask

   initial begin
      logic [4:0] addrs [8];
      addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd30, 5'd0};
      set_idle();
      ext_int = 0;
      rst = 1;
      tick(); tick();
      rst = 0;
      chk("reset_status", cp0_status, 32'h0040_0000);
      chk("reset_count", cp0_count, 32'h0);
      chk("reset_rv", 32'(redirect_valid), 32'h0);
      repeat (10) tick();
      chk("count_after_10", cp0_count, 32'd5);

      // Overflow in a delay slot with EXL=0.
      do_exc(5'd12, 1, 32'h8000_1000, 32'hBFC0_0380, 32'h0, 0);
      tick();
      chk("ov_epc", cp0_epc, 32'h8000_0FFC);
      chk("ov_bd", 32'(cp0_cause[31]), 32'h1);
      chk("ov_exccode", 32'(cp0_cause[6:2]), 32'h0C);
      chk("ov_exl", 32'(cp0_status[1]), 32'h1);
      chk("ov_rv", 32'(redirect_valid), 32'h1);
      chk("ov_rpc", redirect_pc, 32'hBFC0_0380);
      tick();
      chk("ov_rv_drop", 32'(redirect_valid), 32'h0);

      // AdEL with EXL already set.
      do_exc(5'd4, 0, 32'h0000_1234, 32'hBFC0_0380, 32'h0000_0003, 0);
      tick();
      chk("adel_epc_kept", cp0_epc, 32'h8000_0FFC);
      chk("adel_exccode", 32'(cp0_cause[6:2]), 32'h4);
      chk("adel_badvaddr", cp0_badvaddr, 32'h3);

      // Timer: Count=0, Compare=6, IM[7]=1.
      do_wr(5'd9, 32'h0); tick();
      do_wr(5'd11, 32'd6); tick();
      do_wr(5'd12, 32'h0040_8000); tick();
      repeat (9) tick();
      tick();
      chk("timer_count6", cp0_count, 32'd6);
      chk("timer_not_yet", 32'(timer_int), 32'h0);
      tick();
      chk("timer_set", 32'(timer_int), 32'h1);
      chk("timer_iflag7", 32'(interrupt_flag[7]), 32'h1);
      do_wr(5'd11, 32'd100); tick();
      chk("timer_clear", 32'(timer_int), 32'h0);

      // ext_int[0] with IM[2].
      do_wr(5'd12, 32'h0040_0400); tick();
      ext_int = 6'h01;
      tick();
      chk("ext_lat1", 32'(interrupt_flag[2]), 32'h0);
      tick();
      chk("ext_lat2", 32'(interrupt_flag[2]), 32'h1);
      ext_int = 0;

      // ERET ordering and same-cycle MTC0 with a syscall.
      do_wr(5'd12, 32'h0040_0006); tick();
      do_exc(5'd0, 0, 32'h0, 32'h0000_1000, 32'h0, 1); tick();
      chk("eret1_erl", 32'(cp0_status[2]), 32'h0);
      chk("eret1_exl", 32'(cp0_status[1]), 32'h1);
      do_exc(5'd0, 0, 32'h0, 32'h0000_2000, 32'h0, 1); tick();
      chk("eret2_exl", 32'(cp0_status[1]), 32'h0);
      do_wr(5'd12, 32'h0040_0001);
      do_exc(5'd8, 0, 32'h0000_3000, 32'hBFC0_0380, 32'h0, 0); tick();
      chk("sys_ie", 32'(cp0_status[0]), 32'h1);
      chk("sys_exl", 32'(cp0_status[1]), 32'h1);

      // Flush while in reset is ignored.
      rst = 1;
      do_exc(5'd12, 0, 32'h1111_0000, 32'hDEAD_BEE0, 32'h0, 0); tick();
      rst = 0;
      chk("rst_flush_rv", 32'(redirect_valid), 32'h0);
      chk("rst_flush_status", cp0_status, 32'h0040_0000);
      chk("rst_flush_epc", cp0_epc, 32'h0);
      tick();
      chk("rst_flush_rv2", 32'(redirect_valid), 32'h0);

      // Randomized traffic checked against the model on every cycle.
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 19) == 0) ext_int = 6'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            wb_cp0_we    = 1;
            wb_cp0_waddr = addrs[$urandom_range(0, 7)];
            wb_cp0_sel   = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd0;
            wb_cp0_wdata = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
         end
         if ($urandom_range(0, 5) == 0) begin
            except_flush     = 1;
            except_eret      = ($urandom_range(0, 2) == 0);
            except_code      = 5'($urandom_range(0, 13));
            except_delayslot = 1'($urandom);
            except_cur_pc    = $urandom & 32'hFFFF_FFFC;
            except_jump_pc   = $urandom;
            except_extra     = $urandom;
         end
         tick();
      end
      rst = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
